// File: rtl/keypoint_collector.sv
// Keypoint collector: zero-fills two keypoint memories, then drains per-layer candidate
// FIFOs onto a shared registered write bus with round-robin arbitration between layers.
module keypoint_collector #(
    parameter int MAX_KPT    = 2000,
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              kpt_valid_1,
    output logic              kpt_ready_1,
    input  logic              kpt_valid_2,
    output logic              kpt_ready_2,
    input  logic [8:0]        kpt_row,
    input  logic [9:0]        kpt_col,
    input  logic              detect_done,
    output logic              mem_we_1,
    output logic              mem_we_2,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [18:0]       mem_wdata,
    output logic [ADDR_W-1:0] kpt_cnt_1,
    output logic [ADDR_W-1:0] kpt_cnt_2,
    output logic [15:0]       drop_cnt,
    output logic              done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0]   MAX_EXT  = (ADDR_W + 1)'(MAX_KPT);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAX_KPT - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [18:0]       fifo_q   [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [CNT_W-1:0]  fcnt_q   [2];
    logic [18:0]       head_s   [2];

    logic [1:0]  valid_s;
    logic [1:0]  ready_s;
    logic [1:0]  push_s;
    logic [1:0]  pop_s;
    logic [1:0]  empty_s;
    logic [1:0]  full_s;
    logic        accepting_s;
    logic [18:0] din_s;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] cnt1_q, cnt1_d;
    logic [ADDR_W-1:0] cnt2_q, cnt2_d;
    logic [15:0]       drop_q, drop_d;
    logic              we1_q, we1_d;
    logic              we2_q, we2_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [18:0]       wdata_q, wdata_d;
    logic              done_q;

    assign din_s       = {kpt_row, kpt_col};
    assign valid_s     = {kpt_valid_2, kpt_valid_1};
    assign accepting_s = (state_q == ST_CLEAR) || (state_q == ST_COLLECT);

    // Per-layer FIFO status; ready depends only on registered state.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            empty_s[l] = (fcnt_q[l] == '0);
            full_s[l]  = (fcnt_q[l] == CNT_W'(FIFO_DEPTH));
            ready_s[l] = !full_s[l] && accepting_s;
            push_s[l]  = valid_s[l] && ready_s[l];
            head_s[l]  = fifo_q[l][rd_ptr_q[l]];
        end
    end

    // FIFO pointer and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                rd_ptr_q[l] <= '0;
                wr_ptr_q[l] <= '0;
                fcnt_q[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push_s[l]) wr_ptr_q[l] <= ptr_inc(wr_ptr_q[l]);
                if (pop_s[l])  rd_ptr_q[l] <= ptr_inc(rd_ptr_q[l]);
                case ({push_s[l], pop_s[l]})
                    2'b10:   fcnt_q[l] <= fcnt_q[l] + CNT_W'(1);
                    2'b01:   fcnt_q[l] <= fcnt_q[l] - CNT_W'(1);
                    default: fcnt_q[l] <= fcnt_q[l];
                endcase
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push_s[l]) fifo_q[l][wr_ptr_q[l]] <= din_s;
        end
    end

    // Frame FSM, arbitration and write-bus next state.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_d      = rr_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        drop_d    = drop_q;
        we1_d     = 1'b0;
        we2_d     = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pop_s     = 2'b00;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    cnt1_d    = '0;
                    cnt2_d    = '0;
                    drop_d    = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CLEAR: begin
                we1_d     = 1'b1;
                we2_d     = 1'b1;
                addr_d    = clr_cnt_q;
                wdata_d   = 19'd0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                rr_d      = 1'b0;
                if (clr_cnt_q == CLR_LAST) state_d = ST_COLLECT;
                else                       state_d = ST_CLEAR;
            end
            ST_COLLECT: begin
                // rr_q set means layer 2 has priority on the next contended cycle.
                if (!empty_s[0] && !empty_s[1]) begin
                    pop_s = rr_q ? 2'b10 : 2'b01;
                    rr_d  = !rr_q;
                end else if (!empty_s[0]) begin
                    pop_s = 2'b01;
                end else if (!empty_s[1]) begin
                    pop_s = 2'b10;
                end else begin
                    pop_s = 2'b00;
                end
                if (pop_s[0]) begin
                    if ({1'b0, cnt1_q} < MAX_EXT) begin
                        we1_d   = 1'b1;
                        addr_d  = cnt1_q;
                        wdata_d = head_s[0];
                        cnt1_d  = cnt1_q + ADDR_W'(1);
                    end else begin
                        drop_d = sat_inc16(drop_q);
                    end
                end else if (pop_s[1]) begin
                    if ({1'b0, cnt2_q} < MAX_EXT) begin
                        we2_d   = 1'b1;
                        addr_d  = cnt2_q;
                        wdata_d = head_s[1];
                        cnt2_d  = cnt2_q + ADDR_W'(1);
                    end else begin
                        drop_d = sat_inc16(drop_q);
                    end
                end else begin
                    drop_d = drop_q;
                end
                if (detect_done && (empty_s == 2'b11) && (push_s == 2'b00)) state_d = ST_DONE;
                else                                                        state_d = ST_COLLECT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            rr_q      <= 1'b0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            drop_q    <= 16'd0;
            we1_q     <= 1'b0;
            we2_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 19'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_q      <= rr_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            drop_q    <= drop_d;
            we1_q     <= we1_d;
            we2_q     <= we2_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign kpt_ready_1 = ready_s[0];
    assign kpt_ready_2 = ready_s[1];
    assign mem_we_1    = we1_q;
    assign mem_we_2    = we2_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign kpt_cnt_1   = cnt1_q;
    assign kpt_cnt_2   = cnt2_q;
    assign drop_cnt    = drop_q;
    assign done        = done_q;

endmodule

// File: tb/tb_keypoint_collector.sv
// Self-checking bench for keypoint_collector: scoreboard queues per layer plus a small
// clear-phase model, with table-driven single-layer vectors and hand-written corner cases.
module tb_keypoint_collector;

    localparam int MAX = 8;
    localparam int AW  = 4;
    localparam int FD  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          kpt_valid_1, kpt_valid_2;
    logic          kpt_ready_1, kpt_ready_2;
    logic [8:0]    kpt_row;
    logic [9:0]    kpt_col;
    logic          detect_done;
    logic          mem_we_1, mem_we_2;
    logic [AW-1:0] mem_addr;
    logic [18:0]   mem_wdata;
    logic [AW-1:0] kpt_cnt_1, kpt_cnt_2;
    logic [15:0]   drop_cnt;
    logic          done;

    keypoint_collector #(.MAX_KPT(MAX), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .kpt_valid_1(kpt_valid_1), .kpt_ready_1(kpt_ready_1),
        .kpt_valid_2(kpt_valid_2), .kpt_ready_2(kpt_ready_2),
        .kpt_row(kpt_row), .kpt_col(kpt_col), .detect_done(detect_done),
        .mem_we_1(mem_we_1), .mem_we_2(mem_we_2), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .kpt_cnt_1(kpt_cnt_1), .kpt_cnt_2(kpt_cnt_2),
        .drop_cnt(drop_cnt), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic [18:0] wdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] q1[$];
    logic [18:0] q2[$];
    int          wseq[$];
    int          acc1, acc2, wr1, wr2, clr_seen, exp_drop, max_addr2;
    logic [18:0] e1_in, e2_in;
    bit          acc1_last, acc2_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete(); q2.delete(); wseq.delete();
        acc1 = 0; acc2 = 0; wr1 = 0; wr2 = 0;
        clr_seen = 0; exp_drop = 0; max_addr2 = 0;
    endtask

    // Record handshakes for the coming edge, then check the write bus after it.
    task automatic tick();
        acc1_last = kpt_valid_1 && kpt_ready_1;
        acc2_last = kpt_valid_2 && kpt_ready_2;
        if (acc1_last) begin
            if (acc1 < MAX) q1.push_back(e1_in); else exp_drop++;
            acc1++;
        end
        if (acc2_last) begin
            if (acc2 < MAX) q2.push_back(e2_in); else exp_drop++;
            acc2++;
        end
        @(negedge clk);
        if (mem_we_1 && mem_we_2) begin
            check("clr_addr", 32'(mem_addr), 32'(clr_seen));
            check("clr_data", 32'(mem_wdata), 32'd0);
            clr_seen++;
        end else if (mem_we_1) begin
            wseq.push_back(1);
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL we1_spurious: got write addr %0h expected no write", mem_addr);
            end else begin
                check("we1_addr", 32'(mem_addr), 32'(wr1));
                check("we1_data", 32'(mem_wdata), 32'(q1.pop_front()));
                wr1++;
            end
        end else if (mem_we_2) begin
            wseq.push_back(2);
            if (int'(mem_addr) > max_addr2) max_addr2 = int'(mem_addr);
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL we2_spurious: got write addr %0h expected no write", mem_addr);
            end else begin
                check("we2_addr", 32'(mem_addr), 32'(wr2));
                check("we2_data", 32'(mem_wdata), 32'(q2.pop_front()));
                wr2++;
            end
        end
    endtask

    task automatic begin_frame();
        model_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (clr_seen < MAX && n < 100) begin tick(); n++; end
        check("clear_len", 32'(clr_seen), 32'(MAX));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check("done_reached", 32'(done), 32'd1);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[3];
        int   n;
        bit   saw_low;
        vecs[0] = '{9'd5, 10'd7, 19'h01407};
        vecs[1] = '{9'd5, 10'd9, 19'h01409};
        vecs[2] = '{9'd6, 10'd1, 19'h01801};

        rst = 1'b1; start = 1'b0; kpt_valid_1 = 1'b0; kpt_valid_2 = 1'b0;
        kpt_row = 9'd0; kpt_col = 10'd0; detect_done = 1'b0;
        e1_in = 19'd0; e2_in = 19'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_we", 32'({mem_we_1, mem_we_2}), 32'd0);
        check("rst_cnt", 32'({kpt_cnt_1, kpt_cnt_2}), 32'd0);
        check("rst_misc", 32'({drop_cnt, done, kpt_ready_1, kpt_ready_2}), 32'd0);
        check("rst_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0;

        // Clear only, detect already finished.
        detect_done = 1'b1;
        begin_frame();
        n = 1;
        while (!done && n < 30) begin tick(); n++; end
        check("done_latency", 32'(n), 32'd10);
        check("clear_count", 32'(clr_seen), 32'(MAX));
        check("clear_cnts", 32'({kpt_cnt_1, kpt_cnt_2, drop_cnt}), 32'd0);
        check("done_ready", 32'({kpt_ready_1, kpt_ready_2}), 32'd0);

        // Single layer, table-driven.
        detect_done = 1'b0;
        begin_frame();
        wait_clear();
        for (int i = 0; i < 3; i++) begin
            kpt_valid_1 = 1'b1;
            kpt_row = vecs[i].row; kpt_col = vecs[i].col; e1_in = vecs[i].wdata;
            n = 0;
            do begin
                tick(); n++;
                if (i == 1 && n == 1) check("latency_t1", 32'({mem_we_1, mem_addr}), 32'({1'b1, 4'd0}));
            end while (!acc1_last && n < 50);
            check("vec_accept", 32'(acc1_last), 32'd1);
        end
        kpt_valid_1 = 1'b0;
        detect_done = 1'b1;
        wait_done();
        check("single_cnt1", 32'(kpt_cnt_1), 32'd3);
        check("single_cnt2", 32'(kpt_cnt_2), 32'd0);

        // Dual push of the same pixel into both layers.
        detect_done = 1'b0;
        begin_frame();
        wait_clear();
        wseq.delete();
        kpt_row = 9'd100; kpt_col = 10'd200;
        e1_in = {9'd100, 10'd200}; e2_in = {9'd100, 10'd200};
        begin
            int na1 = 0, na2 = 0;
            saw_low = 1'b0; n = 0;
            while ((na1 < 4 || na2 < 4) && n < 100) begin
                kpt_valid_1 = (na1 < 4); kpt_valid_2 = (na2 < 4);
                tick(); n++;
                if (acc1_last) na1++;
                if (acc2_last) na2++;
                if (!kpt_ready_1 || !kpt_ready_2) saw_low = 1'b1;
            end
        end
        kpt_valid_1 = 1'b0; kpt_valid_2 = 1'b0;
        detect_done = 1'b1;
        wait_done();
        check("dual_cnt", 32'({kpt_cnt_1, kpt_cnt_2}), 32'({4'd4, 4'd4}));
        check("dual_ready_low", 32'(saw_low), 32'd1);
        check("dual_nwrites", 32'(wseq.size()), 32'd8);
        for (int k = 0; k < 8 && k < wseq.size(); k++)
            check("dual_alternate", 32'(wseq[k]), 32'((k % 2) + 1));

        // Layer-2 overflow beyond MAX entries.
        detect_done = 1'b0;
        begin_frame();
        wait_clear();
        for (int k = 0; k < 10; k++) begin
            kpt_valid_2 = 1'b1;
            kpt_row = 9'(k + 3); kpt_col = 10'(k * 7 + 1);
            e2_in = {kpt_row, kpt_col};
            n = 0;
            do begin tick(); n++; end while (!acc2_last && n < 50);
        end
        kpt_valid_2 = 1'b0;
        detect_done = 1'b1;
        wait_done();
        check("ovf_cnt2", 32'(kpt_cnt_2), 32'(MAX));
        check("ovf_drop", 32'(drop_cnt), 32'(exp_drop));
        check("ovf_drop_abs", 32'(drop_cnt), 32'd2);
        check("ovf_addr_bound", 32'(max_addr2 < MAX), 32'd1);

        // Candidates buffered while the memories are still being cleared.
        detect_done = 1'b0;
        begin_frame();
        kpt_valid_1 = 1'b1; kpt_row = 9'd1; kpt_col = 10'd1; e1_in = {9'd1, 10'd1};
        tick();
        check("clr_acc1", 32'(acc1_last), 32'd1);
        kpt_row = 9'd2; kpt_col = 10'd2; e1_in = {9'd2, 10'd2};
        tick();
        check("clr_acc2", 32'(acc1_last), 32'd1);
        kpt_row = 9'd3; kpt_col = 10'd3; e1_in = {9'd3, 10'd3};
        check("clr_full_ready", 32'(kpt_ready_1), 32'd0);
        wait_clear();
        tick();
        check("post_clear_write", 32'({mem_we_1, mem_we_2, mem_addr}), 32'({2'b10, 4'd0}));
        n = 0;
        while (!acc1_last && n < 50) begin tick(); n++; end
        kpt_valid_1 = 1'b0;
        detect_done = 1'b1;
        wait_done();
        check("buf_cnt1", 32'(kpt_cnt_1), 32'd3);

        // Asynchronous reset in the middle of a collection stream.
        detect_done = 1'b0;
        begin_frame();
        wait_clear();
        kpt_valid_1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            kpt_row = 9'(20 + k); kpt_col = 10'(40 + k); e1_in = {kpt_row, kpt_col};
            tick();
        end
        check("pre_rst_we1", 32'(mem_we_1), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_we", 32'({mem_we_1, mem_we_2}), 32'd0);
        check("rst_mid_cnt", 32'({kpt_cnt_1, kpt_cnt_2, drop_cnt}), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        kpt_valid_1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        detect_done = 1'b1;
        begin_frame();
        wait_clear();
        wait_done();
        check("restart_cnt", 32'({kpt_cnt_1, kpt_cnt_2}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
